// File: rtl/merger_lane_buffer_if.sv
// Handshake bundle between the lane buffer, its two stream producers and the binary merger.
interface merger_lane_buffer_if #(
  parameter int W = 32
);
  logic           start;
  logic [2*W-1:0] in_coord;
  logic [1:0]     in_last;
  logic [1:0]     in_valid;
  logic [1:0]     in_ready;
  logic [2*W-1:0] coord_out;
  logic           selected;
  logic [1:0]     fetch_next;
  logic           out_ready;
  logic           merged_valid;
  logic           done;
  logic           err;

  modport slave (
    input  start, in_coord, in_last, in_valid, fetch_next, out_ready,
    output in_ready, coord_out, selected, merged_valid, done, err
  );

  modport master (
    output start, in_coord, in_last, in_valid, fetch_next, out_ready,
    input  in_ready, coord_out, selected, merged_valid, done, err
  );
endinterface

// File: rtl/merger_lane_buffer.sv
// Two-lane coordinate buffer feeding binary_merger: per-lane FIFOs, end-of-stream
// sentinel substitution and the merged-output valid/ready handshake.
module merger_lane_buffer #(
  parameter int MERGER_COORD_BITS = 32,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                clock,
  input  logic                reset,
  merger_lane_buffer_if.slave bus
);

  localparam int W     = MERGER_COORD_BITS;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [W-1:0]     SENTINEL = {W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_MERGE = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [W:0]       r_mem   [2][FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr  [2];
  logic [PTR_W-1:0] r_rptr  [2];
  logic [CNT_W-1:0] r_count [2];
  logic [1:0]       r_ended;
  logic             r_err;

  logic [W:0]     w_head [2];
  logic [1:0]     w_full;
  logic [1:0]     w_head_real;
  logic [1:0]     w_lane_ok;
  logic [1:0]     w_push;
  logic [1:0]     w_pop;
  logic [1:0]     w_pop_last;
  logic           w_in_merge;
  logic           w_start_clr;
  logic           w_done;
  logic           w_merged_valid;
  logic           w_selected;
  logic           w_err_evt;
  logic [2*W-1:0] w_coord_out;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return PTR_ZERO;
    end else begin
      return p + PTR_ONE;
    end
  endfunction

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start is only honoured outside MERGE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = ST_MERGE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MERGE: begin
        if (r_ended == 2'b11) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_MERGE;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          w_state_nxt = ST_MERGE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    w_in_merge  = 1'b0;
    w_done      = 1'b0;
    w_start_clr = 1'b0;
    case (r_state)
      ST_IDLE:  w_start_clr = bus.start;
      ST_MERGE: w_in_merge  = 1'b1;
      ST_DONE: begin
        w_done      = 1'b1;
        w_start_clr = bus.start;
      end
      default: w_in_merge = 1'b0;
    endcase
  end

  // Per-lane FIFO status; an ended lane hides whatever is still queued behind it.
  always_comb begin
    w_full      = 2'b00;
    w_head_real = 2'b00;
    w_lane_ok   = 2'b00;
    w_push      = 2'b00;
    for (int i = 0; i < 2; i++) begin
      w_head[i]      = r_mem[i][r_rptr[i]];
      w_full[i]      = (r_count[i] == CNT_FULL);
      w_head_real[i] = (r_count[i] != CNT_ZERO) & ~r_ended[i];
      w_lane_ok[i]   = w_head_real[i] | r_ended[i];
      w_push[i]      = bus.in_valid[i] & ~w_full[i];
    end
  end

  // Merge handshake, protocol checking and head presentation.
  always_comb begin
    w_merged_valid = w_in_merge & w_lane_ok[0] & w_lane_ok[1] & ~(r_ended[0] & r_ended[1]);
    w_selected     = w_merged_valid & bus.out_ready;
    w_err_evt      = ((bus.fetch_next != 2'b00) & ~w_selected)
                   | ((bus.fetch_next & ~w_head_real) != 2'b00)
                   | (bus.fetch_next == 2'b11);
    if (w_err_evt) begin
      w_pop = 2'b00;
    end else begin
      w_pop = bus.fetch_next & {2{w_selected}} & w_head_real;
    end
    w_pop_last  = 2'b00;
    w_coord_out = {2*W{1'b1}};
    for (int i = 0; i < 2; i++) begin
      w_pop_last[i] = w_pop[i] & w_head[i][W];
      if (w_head_real[i]) begin
        w_coord_out[i*W +: W] = w_head[i][W-1:0];
      end else begin
        w_coord_out[i*W +: W] = SENTINEL;
      end
    end
  end

  // FIFO storage; flushing is done through the pointers, so the array needs no reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wptr[i]] <= {bus.in_last[i], bus.in_coord[i*W +: W]};
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        r_wptr[i]  <= PTR_ZERO;
        r_rptr[i]  <= PTR_ZERO;
        r_count[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_push[i]) begin
          r_wptr[i] <= ptr_inc(r_wptr[i]);
        end
        if (w_pop[i]) begin
          r_rptr[i] <= ptr_inc(r_rptr[i]);
        end
        case ({w_push[i], w_pop[i]})
          2'b10:   r_count[i] <= r_count[i] + CNT_ONE;
          2'b01:   r_count[i] <= r_count[i] - CNT_ONE;
          default: r_count[i] <= r_count[i];
        endcase
      end
    end
  end

  // Stream-ended flags and the sticky protocol error; start re-arms both.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ended <= 2'b00;
      r_err   <= 1'b0;
    end else begin
      if (w_start_clr) begin
        r_ended <= 2'b00;
      end else begin
        r_ended <= r_ended | w_pop_last;
      end
      r_err <= (r_err & ~w_start_clr) | w_err_evt;
    end
  end

  assign bus.in_ready     = ~w_full;
  assign bus.coord_out    = w_coord_out;
  assign bus.merged_valid = w_merged_valid;
  assign bus.selected     = w_selected;
  assign bus.done         = w_done;
  assign bus.err          = r_err;

endmodule

// File: tb/tb_merger_lane_buffer.sv
// Directed bench for merger_lane_buffer: queue-based reference model checked every cycle,
// an emulated binary_merger, and hand-computed expectations per scenario.
module tb_merger_lane_buffer;
  localparam int W = 32;
  localparam int D = 4;
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic       clock     = 1'b0;
  logic       reset     = 1'b0;
  logic       merger_on = 1'b0;
  logic [1:0] fn_manual = 2'b00;
  int         checks    = 0;
  int         errors    = 0;
  logic [W-1:0] got [$];

  merger_lane_buffer_if #(.W(W)) bus ();

  merger_lane_buffer #(.MERGER_COORD_BITS(W), .FIFO_DEPTH(D)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Emulated merger: smaller head wins, ties go to lane1; fetch only when selected.
  always_comb begin
    logic [1:0] pick;
    pick = 2'b00;
    if (bus.selected) begin
      pick = (bus.coord_out[2*W-1:W] <= bus.coord_out[W-1:0]) ? 2'b10 : 2'b01;
    end
    bus.fetch_next = merger_on ? pick : fn_manual;
  end

  typedef enum {M_IDLE, M_MERGE, M_DONE} mstate_t;
  mstate_t    m_state = M_IDLE;
  logic [W:0] mq0 [$];
  logic [W:0] mq1 [$];
  logic [1:0] m_ended = 2'b00;
  logic       m_err   = 1'b0;

  function automatic int m_size(input int i);
    return (i == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [W:0] m_front(input int i);
    return (i == 0) ? mq0[0] : mq1[0];
  endfunction

  function automatic logic m_real(input int i);
    return (m_size(i) > 0) && !m_ended[i];
  endfunction

  function automatic logic [W-1:0] m_coord(input int i);
    logic [W:0] e;
    if (!m_real(i)) return ONES;
    e = m_front(i);
    return e[W-1:0];
  endfunction

  function automatic logic m_mv();
    return (m_state == M_MERGE) && (m_real(0) || m_ended[0]) && (m_real(1) || m_ended[1])
           && !(m_ended == 2'b11);
  endfunction

  task automatic model_step();
    logic       sel, bad, clr;
    logic [1:0] fn, pops, pushes;
    logic [W:0] e;
    mstate_t    nxt;
    fn  = bus.fetch_next;
    sel = m_mv() && bus.out_ready;
    bad = ((fn != 2'b00) && !sel) || (fn[0] && !m_real(0)) || (fn[1] && !m_real(1)) || (fn == 2'b11);
    for (int i = 0; i < 2; i++) begin
      pops[i]   = !bad && fn[i] && sel && m_real(i);
      pushes[i] = bus.in_valid[i] && (m_size(i) < D);
    end
    clr = bus.start && (m_state != M_MERGE);
    nxt = m_state;
    if (m_state == M_MERGE) begin
      if (m_ended == 2'b11) nxt = M_DONE;
    end else if (bus.start) begin
      nxt = M_MERGE;
    end
    if (clr) begin
      m_ended = 2'b00;
      m_err   = 1'b0;
    end
    if (bad) m_err = 1'b1;
    if (pops[0]) begin
      e = mq0.pop_front();
      if (e[W]) m_ended[0] = 1'b1;
    end
    if (pops[1]) begin
      e = mq1.pop_front();
      if (e[W]) m_ended[1] = 1'b1;
    end
    if (pushes[0]) mq0.push_back({bus.in_last[0], bus.in_coord[W-1:0]});
    if (pushes[1]) mq1.push_back({bus.in_last[1], bus.in_coord[2*W-1:W]});
    m_state = nxt;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model advances on the same edges as the design.
  initial begin
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        mq0.delete();
        mq1.delete();
        m_ended = 2'b00;
        m_err   = 1'b0;
        m_state = M_IDLE;
      end else begin
        model_step();
      end
    end
  end

  // Per-cycle compare against the model, plus capture of merged output values.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        check("in_ready", 64'(bus.in_ready), 64'({m_size(1) < D, m_size(0) < D}));
        check("coord_out", 64'(bus.coord_out), 64'({m_coord(1), m_coord(0)}));
        check("merged_valid", 64'(bus.merged_valid), 64'(m_mv()));
        check("selected", 64'(bus.selected), 64'(m_mv() && bus.out_ready));
        check("done", 64'(bus.done), 64'(m_state == M_DONE));
        check("err", 64'(bus.err), 64'(m_err));
        if (bus.selected) begin
          got.push_back((bus.coord_out[2*W-1:W] <= bus.coord_out[W-1:0]) ?
                        bus.coord_out[2*W-1:W] : bus.coord_out[W-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push2(input logic [1:0] v, input logic [W-1:0] c0, input logic [W-1:0] c1,
                       input logic [1:0] l);
    bus.in_valid = v;
    bus.in_coord = {c1, c0};
    bus.in_last  = l;
    tick();
    bus.in_valid = 2'b00;
    bus.in_last  = 2'b00;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!bus.done && n < 40) begin
      tick();
      n++;
    end
    check(name, 64'(bus.done), 64'd1);
  endtask

  function automatic logic [W-1:0] got_at(input int k);
    if (k < got.size()) return got[k];
    return ONES;
  endfunction

  task automatic check_seq(input string name, input logic [W-1:0] exp [$]);
    check({name, "_len"}, 64'(got.size()), 64'(exp.size()));
    foreach (exp[k]) check(name, 64'(got_at(k)), 64'(exp[k]));
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.in_coord  = {2*W{1'b0}};
    bus.in_last   = 2'b00;
    bus.in_valid  = 2'b00;
    bus.out_ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("t1_in_ready", 64'(bus.in_ready), 64'h3);
    check("t1_coord_out", 64'(bus.coord_out), 64'({ONES, ONES}));
    check("t1_selected", 64'(bus.selected), 64'd0);
    check("t1_merged_valid", 64'(bus.merged_valid), 64'd0);
    check("t1_done", 64'(bus.done), 64'd0);
    check("t1_err", 64'(bus.err), 64'd0);
    tick();

    // Basic merge: 1,4,9 with 2,3.
    push2(2'b11, 32'd1, 32'd2, 2'b00);
    push2(2'b11, 32'd4, 32'd3, 2'b10);
    push2(2'b01, 32'd9, 32'd0, 2'b01);
    got.delete();
    merger_on     = 1'b1;
    bus.out_ready = 1'b1;
    pulse_start();
    wait_done("t2_done");
    check_seq("t2_seq", '{32'd1, 32'd2, 32'd3, 32'd4, 32'd9});
    check("t2_mv_after", 64'(bus.merged_valid), 64'd0);

    // Lane1 ends early; lane0 continues against the sentinel.
    push2(2'b11, 32'd7, 32'd5, 2'b10);
    push2(2'b01, 32'd8, 32'd0, 2'b01);
    got.delete();
    pulse_start();
    tick();
    @(negedge clock);
    check("t3_lane1_sentinel", 64'(bus.coord_out[2*W-1:W]), 64'(ONES));
    check("t3_lane0_head", 64'(bus.coord_out[W-1:0]), 64'd7);
    wait_done("t3_done");
    check_seq("t3_seq", '{32'd5, 32'd7, 32'd8});

    // Full lane refuses a push even while popping.
    merger_on = 1'b0;
    fn_manual = 2'b00;
    push2(2'b11, 32'd10, 32'd50, 2'b10);
    push2(2'b01, 32'd20, 32'd0, 2'b00);
    push2(2'b01, 32'd30, 32'd0, 2'b00);
    push2(2'b01, 32'd40, 32'd0, 2'b01);
    @(negedge clock);
    check("t4_full", 64'(bus.in_ready[0]), 64'd0);
    got.delete();
    pulse_start();
    fn_manual    = 2'b01;
    bus.in_valid = 2'b01;
    bus.in_coord = {32'd0, 32'd99};
    @(negedge clock);
    check("t4_full_during_pop", 64'(bus.in_ready[0]), 64'd0);
    check("t4_selected", 64'(bus.selected), 64'd1);
    tick();
    fn_manual    = 2'b00;
    bus.in_valid = 2'b00;
    merger_on    = 1'b1;
    @(negedge clock);
    check("t4_ready_again", 64'(bus.in_ready[0]), 64'd1);
    check("t4_head", 64'(bus.coord_out[W-1:0]), 64'd20);
    wait_done("t4_done");
    check_seq("t4_seq", '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50});

    // Empty but live lane stalls the merge until it gets data.
    got.delete();
    push2(2'b01, 32'd3, 32'd0, 2'b01);
    pulse_start();
    @(negedge clock);
    check("t5_stall_mv", 64'(bus.merged_valid), 64'd0);
    tick();
    @(negedge clock);
    check("t5_no_pop", 64'(bus.coord_out[W-1:0]), 64'd3);
    check("t5_stall_mv2", 64'(bus.merged_valid), 64'd0);
    push2(2'b10, 32'd0, 32'd2, 2'b10);
    @(negedge clock);
    check("t5_mv", 64'(bus.merged_valid), 64'd1);
    check("t5_lane1_head", 64'(bus.coord_out[2*W-1:W]), 64'd2);
    wait_done("t5_done");
    check_seq("t5_seq", '{32'd2, 32'd3});

    // Illegal fetch sets sticky err without popping; reset mid-merge flushes.
    merger_on = 1'b0;
    fn_manual = 2'b00;
    push2(2'b11, 32'd6, 32'd7, 2'b00);
    pulse_start();
    bus.out_ready = 1'b0;
    fn_manual     = 2'b01;
    tick();
    fn_manual = 2'b00;
    @(negedge clock);
    check("t6_err", 64'(bus.err), 64'd1);
    check("t6_no_pop", 64'(bus.coord_out[W-1:0]), 64'd6);
    tick();
    tick();
    @(negedge clock);
    check("t6_err_sticky", 64'(bus.err), 64'd1);
    tick();
    reset = 1'b0;
    #2;
    check("t6_rst_in_ready", 64'(bus.in_ready), 64'h3);
    check("t6_rst_coord", 64'(bus.coord_out), 64'({ONES, ONES}));
    check("t6_rst_err", 64'(bus.err), 64'd0);
    check("t6_rst_done", 64'(bus.done), 64'd0);
    check("t6_rst_mv", 64'(bus.merged_valid), 64'd0);
    tick();
    tick();
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    merger_on     = 1'b1;
    push2(2'b11, 32'd1, 32'd2, 2'b11);
    tick();
    @(negedge clock);
    check("t6_idle_after_reset", 64'(bus.merged_valid), 64'd0);
    got.delete();
    pulse_start();
    @(negedge clock);
    check("t6_mv_after_start", 64'(bus.merged_valid), 64'd1);
    wait_done("t6_done");
    check_seq("t6_seq", '{32'd1, 32'd2});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
